path_count_stream: RTL and testbench

//  Streaming DAG path counter. Consumes a post-order (children-first) node list over a

---
 rtl/path_count_stream.sv | 236 +++++++++++++++++++++++
 tb/tb_path_count_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/path_count_stream.sv
// path_count_stream: streaming DAG path counter.
//   Consumes a post-order (children-first) node list and counts the paths from src
//   to dst modulo 2^CNT_W. Per-node counts live in an on-chip table; a per-node
//   written bit means the table is cleared in one cycle on start.
//   Optional macro PCS_WAYPOINT_EN: four counters per node, one per visited
//   waypoint subset {sawB, sawA}; the result is the "visited both" lane.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   start_i                    begin a run (ignored while busy)
//   src_id_i, dst_id_i         result node / seeded sink node
//   via_a_id_i, via_b_id_i     waypoints (waypoint build only)
//   in_valid_i, in_ready_o     word handshake
//   in_data_i, in_last_i       header {node, nchild} or child {16'b0, id}; last word
//   busy_o, done_o             run in progress / result valid (sticky)
//   total_paths_o              path count
//   overflow_o, err_o          sticky carry-out / bad-id flags

module pcs_lane_add #(
  parameter int CNT_W = 64
) (
  input  logic [CNT_W-1:0] a_i,
  input  logic [CNT_W-1:0] b_i,
  output logic [CNT_W-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module path_count_stream #(
  parameter int NODE_W    = 16,
  parameter int NUM_NODES = 1024,
  parameter int CNT_W     = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [NODE_W-1:0] src_id_i,
  input  logic [NODE_W-1:0] dst_id_i,
  input  logic [NODE_W-1:0] via_a_id_i,
  input  logic [NODE_W-1:0] via_b_id_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_data_i,
  input  logic              in_last_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  total_paths_o,
  output logic              overflow_o,
  output logic              err_o
);
`ifdef PCS_WAYPOINT_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif
  localparam int AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CH, S_WR, S_DONE} state_e;
  typedef logic [LANES-1:0][CNT_W-1:0] cnt_t;

  state_e state_q, state_d;
  logic [NODE_W-1:0] src_q, dst_q;
  logic [15:0]       node_q, rem_q;
  logic              last_q, rd_pend_q, rd_hit_q;
  cnt_t              acc_q, rd_raw_q, rd_eff, acc_nxt, wr_val, seed;
  logic [LANES-1:0]  add_cy;
  logic              map_cy;
  logic [NUM_NODES-1:0] written_q;
  cnt_t              mem [NUM_NODES];
  logic [CNT_W-1:0]  total_q;
  logic              done_q, ovf_q, err_q;

  // word decode
  logic          acc_w, hi_oor, lo_oor, node_oor, hdr_is_dst, node_is_src;
  logic [15:0]   hi16, lo16;
  logic [AW-1:0] lo_idx, node_idx;

  assign acc_w       = in_valid_i & in_ready_o;
  assign hi16        = in_data_i[31:16];
  assign lo16        = in_data_i[15:0];
  assign hi_oor      = {16'b0, hi16}   >= 32'(NUM_NODES);
  assign lo_oor      = {16'b0, lo16}   >= 32'(NUM_NODES);
  assign node_oor    = {16'b0, node_q} >= 32'(NUM_NODES);
  assign lo_idx      = lo16[AW-1:0];
  assign node_idx    = node_q[AW-1:0];
  assign hdr_is_dst  = {16'b0, hi16}   == 32'(dst_q);
  assign node_is_src = {16'b0, node_q} == 32'(src_q);

  // Child read data lands one cycle after acceptance and is folded into acc here.
  // The HDR cycle always separates a WR from the next child read, so a child that
  // names a just-written node already sees its count in the table.
  assign rd_eff = (rd_pend_q & rd_hit_q) ? rd_raw_q : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pcs_lane_add #(.CNT_W(CNT_W)) u_add (
      .a_i    (acc_q[l]),
      .b_i    (rd_eff[l]),
      .sum_o  (acc_nxt[l]),
      .carry_o(add_cy[l])
    );
  end

`ifdef PCS_WAYPOINT_EN
  logic [NODE_W-1:0] via_a_q, via_b_q;
  logic hit_a, hit_b, hdr_a, hdr_b;
  assign hit_a = {16'b0, node_q} == 32'(via_a_q);
  assign hit_b = {16'b0, node_q} == 32'(via_b_q);
  assign hdr_a = {16'b0, hi16}   == 32'(via_a_q);
  assign hdr_b = {16'b0, hi16}   == 32'(via_b_q);

  always_comb begin
    seed = '0;
    if (hdr_is_dst) seed[{hdr_b, hdr_a}] = CNT_W'(1);
  end

  // Waypoint node: lane m moves to m|{hitB,hitA}; colliding lanes are summed.
  always_comb begin
    logic [1:0]     tgt;
    logic [CNT_W:0] s;
    tgt    = '0;
    s      = '0;
    wr_val = '0;
    map_cy = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tgt         = 2'(m) | {hit_b, hit_a};
      s           = {1'b0, wr_val[tgt]} + {1'b0, acc_nxt[m]};
      wr_val[tgt] = s[CNT_W-1:0];
      map_cy      = map_cy | s[CNT_W];
    end
  end
`else
  logic unused_via;
  assign unused_via = ^{via_a_id_i, via_b_id_i};

  always_comb begin
    seed       = '0;
    seed[0][0] = hdr_is_dst;
  end

  assign wr_val = acc_nxt;
  assign map_cy = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_HDR;
      // a header with in_last cannot be followed by children; close the node now
      S_HDR: if (acc_w) state_d = (lo16 == 16'd0 || in_last_i) ? S_WR : S_CH;
      S_CH:  if (acc_w && (rem_q == 16'd1 || in_last_i)) state_d = S_WR;
      S_WR:  state_d = (node_is_src || last_q) ? S_DONE : S_HDR;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = (state_q == S_HDR) || (state_q == S_CH);
    busy_o     = in_ready_o || (state_q == S_WR);
  end

  assign done_o        = done_q;
  assign total_paths_o = total_q;
  assign overflow_o    = ovf_q;
  assign err_o         = err_q;

  // datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= '0; dst_q <= '0; node_q <= '0; rem_q <= '0;
      last_q <= 1'b0; rd_pend_q <= 1'b0; rd_hit_q <= 1'b0;
      acc_q <= '0; written_q <= '0; total_q <= '0;
      done_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0;
`ifdef PCS_WAYPOINT_EN
      via_a_q <= '0; via_b_q <= '0;
`endif
    end else begin
      // rd_eff is zero outside CH/WR, so only real accumulations can carry
      ovf_q <= ovf_q | (|add_cy) | ((state_q == S_WR) & map_cy);
      unique case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          src_q <= src_id_i; dst_q <= dst_id_i;
`ifdef PCS_WAYPOINT_EN
          via_a_q <= via_a_id_i; via_b_q <= via_b_id_i;
`endif
          written_q <= '0; total_q <= '0;
          done_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0;
        end
        S_HDR: if (acc_w) begin
          node_q    <= hi16;
          rem_q     <= lo16;
          acc_q     <= seed;
          rd_pend_q <= 1'b0;
          last_q    <= in_last_i;
          if (hi_oor || (in_last_i && lo16 != 16'd0)) err_q <= 1'b1;
        end
        S_CH: begin
          acc_q     <= acc_nxt;
          rd_pend_q <= acc_w;
          if (acc_w) begin
            rem_q    <= rem_q - 16'd1;
            rd_hit_q <= !lo_oor && written_q[lo_idx];
            last_q   <= last_q | in_last_i;
            if (lo_oor) err_q <= 1'b1;
          end
        end
        S_WR: begin
          rd_pend_q <= 1'b0;
          if (!node_oor) written_q[node_idx] <= 1'b1;
          if (node_is_src) begin
            total_q <= wr_val[LANES-1];
            done_q  <= 1'b1;
          end else if (last_q) begin
            total_q <= '0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // count table; contents are qualified by written_q, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (state_q == S_WR && !node_oor) mem[node_idx] <= wr_val;
    if (state_q == S_CH && acc_w)     rd_raw_q <= mem[lo_idx];
  end

endmodule

// File: tb/tb_path_count_stream.sv
// Directed self-checking bench for path_count_stream (CNT_W=4 so the overflow case is short).
module tb_path_count_stream;
  localparam int NODE_W = 16, NUM_NODES = 1024, CNT_W = 4;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NODE_W-1:0] src_id = '0, dst_id = '0, via_a_id = '0, via_b_id = '0;
  logic              in_valid = 1'b0, in_last = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready, busy, done, overflow, err;
  logic [CNT_W-1:0]  total_paths;

  int errors = 0, checks = 0;
  int lowcnt = 0;
  bit mon_en = 1'b0;

  path_count_stream #(.NODE_W(NODE_W), .NUM_NODES(NUM_NODES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .src_id_i(src_id), .dst_id_i(dst_id), .via_a_id_i(via_a_id), .via_b_id_i(via_b_id),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .busy_o(busy), .done_o(done), .total_paths_o(total_paths),
    .overflow_o(overflow), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && busy && !in_ready) lowcnt++;

  // all drivers assume they are entered on a negedge
  task automatic pulse_start(input logic [15:0] s, d, a, b);
    src_id = s; dst_id = d; via_a_id = a; via_b_id = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_ready: in_ready stuck at %b for word %h", in_ready, d);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: done=%b want 1", tag, done); end
  endtask

  task automatic check_total(input string tag, input logic [CNT_W-1:0] exp);
    checks++;
    if (total_paths !== exp) begin
      errors++; $display("FAIL %s_total: total_paths=%0d want %0d", tag, total_paths, exp);
    end
  endtask

  task automatic stream_t1(input bit gap);
    logic [31:0] w [8];
    w = '{32'h00030000, 32'h00010001, 32'h00000003, 32'h00020001,
          32'h00000003, 32'h00000002, 32'h00000001, 32'h00000002};
    for (int i = 0; i < 8; i++) begin
      send(w[i], i == 7);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: %b want 0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: %b want 0", done); end
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready: %b want 0", in_ready); end
    if (total_paths !== '0)   begin errors++; $display("FAIL rst_total: %0d want 0", total_paths); end
    if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_ovf: %b want 0", overflow); end
    if (err !== 1'b0)         begin errors++; $display("FAIL rst_err: %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ready: ready=%b busy=%b want 0 0", in_ready, busy);
    end
  endtask

  // T1 plus a start pulse mid-stream that must be ignored
  task automatic test_basic();
    logic [31:0] w [8];
    w = '{32'h00030000, 32'h00010001, 32'h00000003, 32'h00020001,
          32'h00000003, 32'h00000002, 32'h00000001, 32'h00000002};
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) pulse_start(16'd3, 16'd1, 16'd3, 16'd3);
      send(w[i], i == 7);
    end
    wait_done("t1");
    check_total("t1", 4'd2);
    checks += 4;
    if (err !== 1'b0)      begin errors++; $display("FAIL t1_err: %b want 0", err); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL t1_ovf: %b want 0", overflow); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL t1_busy: %b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t1_ready: %b want 0", in_ready); end
  endtask

  task automatic test_gapped();
    lowcnt = 0;
    mon_en = 1'b1;
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    stream_t1(1'b1);
    wait_done("t2");
    mon_en = 1'b0;
    check_total("t2", 4'd2);
    checks++;
    if (lowcnt !== 4) begin errors++; $display("FAIL t2_ready_low: %0d cycles want 4", lowcnt); end
  endtask

  task automatic test_no_dst();
    pulse_start(16'd0, 16'd5, 16'd0, 16'd0);
    send(32'h00020000, 1'b0);
    send(32'h00010001, 1'b0); send(32'h00000002, 1'b0);
    send(32'h00000001, 1'b0); send(32'h00000001, 1'b1);
    wait_done("t3a");
    check_total("t3a", 4'd0);
    // src never reached: the in_last node ends the run with zero
    pulse_start(16'd9, 16'd3, 16'd9, 16'd9);
    send(32'h00030000, 1'b1);
    wait_done("t3b");
    check_total("t3b", 4'd0);
  endtask

  task automatic test_overflow();
    pulse_start(16'd1, 16'd20, 16'd1, 16'd1);
    send(32'h00140000, 1'b0);
    for (int n = 10; n <= 11; n++) begin send({16'(n), 16'd1}, 1'b0); send(32'd20, 1'b0); end
    for (int p = 8; p >= 2; p -= 2)
      for (int n = p; n <= p + 1; n++) begin
        send({16'(n), 16'd2}, 1'b0); send(32'(p + 2), 1'b0); send(32'(p + 3), 1'b0);
      end
    send(32'h00010002, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    wait_done("t4");
    check_total("t4", 4'd0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf: %b want 1", overflow); end
  endtask

  task automatic test_bad_id();
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    send(32'h00030000, 1'b0);
    send(32'h00000002, 1'b0); send(32'h00000003, 1'b0); send(32'h0000FFFF, 1'b1);
    wait_done("t5");
    check_total("t5", 4'd1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL t5_err: %b want 1", err); end
    // header carrying in_last with children pending
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL hl_err_clr: %b want 0", err); end
    send(32'h00030000, 1'b0);
    send(32'h00000002, 1'b1);
    wait_done("hl");
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL hl_err: %b want 1", err); end
  endtask

  task automatic test_waypoint();
    pulse_start(16'd0, 16'd3, 16'd1, 16'd2);
    send(32'h00030000, 1'b0);
    send(32'h00020001, 1'b0); send(32'h00000003, 1'b0);
    send(32'h00010001, 1'b0); send(32'h00000002, 1'b0);
    send(32'h00000001, 1'b0); send(32'h00000001, 1'b1);
    wait_done("chain");
    check_total("chain", 4'd1);
    pulse_start(16'd0, 16'd3, 16'd1, 16'd2);
    stream_t1(1'b0);
    wait_done("via");
`ifdef PCS_WAYPOINT_EN
    check_total("via", 4'd0);
`else
    check_total("via", 4'd2);
`endif
  endtask

  task automatic test_mid_reset();
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    send(32'h00030000, 1'b0);
    send(32'h00010001, 1'b0); send(32'h00000003, 1'b0);
    send(32'h00020001, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)     begin errors++; $display("FAIL t7_busy: %b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t7_ready: %b want 0", in_ready); end
    if (done !== 1'b0)     begin errors++; $display("FAIL t7_done0: %b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(16'd0, 16'd3, 16'd0, 16'd0);
    stream_t1(1'b0);
    wait_done("t7");
    check_total("t7", 4'd2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_no_dst();
    test_overflow();
    test_bad_id();
    test_waypoint();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
